eai_itf_mq: RTL and testbench

Next-generation EAI coprocessor interface for the HWPE. It accepts up to QDEPTH outstanding CUSTOM0 instructions into an in-order queue, dispatches them one at a time to the HWPE engine over a start/done handshake, and returns in-order responses tagged with itag. Instructions that write memory drive a parametrised ICB write-back engine with configurable stride and outstanding-command limit, and per-instruction error capture.

---
 rtl/eai_itf_pkg.sv | 25 ++
 rtl/eai_instr_fifo.sv | 50 +++++
 rtl/eai_itf_mq.sv | 183 ++++++++++++++++++
 tb/tb_eai_itf_mq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eai_itf_pkg.sv
// Shared types and constants for the EAI multi-queue coprocessor interface.
// Holds the CUSTOM0 opcode, FSM states, the queue entry header and the ICB mask width helper.
package eai_itf_pkg;

    localparam logic [6:0] CUSTOM0 = 7'b0001011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_BUSY,
        ST_RESP
    } eai_state_e;

    // Width-independent part of a queue entry; operands are appended by the top.
    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  itag;
    } eai_hdr_t;

    function automatic int wmask_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/eai_instr_fifo.sv
// In-order instruction queue: QDEPTH-entry synchronous FIFO with full/empty flags.
// Push and pop may occur in the same cycle, including when full.
module eai_instr_fifo #(
    parameter int QDEPTH = 4,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(QDEPTH);

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(QDEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/eai_itf_mq.sv
// EAI coprocessor interface: queues CUSTOM0 instructions, dispatches them to the HWPE engine
// in order and streams engine write-back beats onto ICB. Optional macro: EAI_ITF_PERF_CNT_EN.
module eai_itf_mq
    import eai_itf_pkg::*;
#(
    parameter int QDEPTH  = 4,
    parameter int DW      = 32,
    parameter int STRIDE  = 8,
    parameter int MAX_OST = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   eai_req_valid_i,
    output logic                   eai_req_ready_o,
    input  logic [31:0]            eai_req_instr_i,
    input  logic [DW-1:0]          eai_req_rs1_i,
    input  logic [DW-1:0]          eai_req_rs2_i,
    input  logic [1:0]             eai_req_itag_i,
    output logic                   eai_rsp_valid_o,
    input  logic                   eai_rsp_ready_i,
    output logic [DW-1:0]          eai_rsp_wdat_o,
    output logic [1:0]             eai_rsp_itag_o,
    output logic                   eai_rsp_err_o,
    output logic                   eai_icb_cmd_valid_o,
    input  logic                   eai_icb_cmd_ready_i,
    output logic [31:0]            eai_icb_cmd_addr_o,
    output logic                   eai_icb_cmd_read_o,
    output logic [DW-1:0]          eai_icb_cmd_wdata_o,
    output logic [wmask_w(DW)-1:0] eai_icb_cmd_wmask_o,
    input  logic                   eai_icb_rsp_valid_i,
    input  logic                   eai_icb_rsp_err_i,
    output logic                   eai_icb_rsp_ready_o,
    input  logic [DW-1:0]          eai_icb_rsp_rdata_i,
    output logic                   eai_mem_holdup_o,
    output logic                   eng_valid_o,
    input  logic                   eng_ready_i,
    output logic [31:0]            eng_instr_o,
    output logic [DW-1:0]          eng_rs1_o,
    output logic [DW-1:0]          eng_rs2_o,
    input  logic                   eng_done_i,
    input  logic                   eng_err_i,
    input  logic [DW-1:0]          eng_result_i,
    input  logic                   eng_wb_i,
    input  logic                   wb_valid_i,
    output logic                   wb_ready_o,
    input  logic [DW-1:0]          wb_data_i,
    input  logic                   wb_last_i,
    output logic [31:0]            perf_busy_cyc_o,
    output logic [31:0]            perf_instr_cnt_o
);
    localparam int OW = $clog2(MAX_OST + 1);

    typedef struct packed {
        eai_hdr_t      hdr;
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
    } entry_t;

    eai_state_e    state_q, state_d;
    entry_t        push_entry, head;
    logic          q_full, q_empty, push, pop;
    logic [OW-1:0] ost_q;
    logic          ost_ok, busy, cmd_hs, ost_dec, done_acc;
    logic [31:0]   addr_q;
    logic [DW-1:0] result_q;
    logic          err_q, done_seen_q, last_seen_q;
    logic          unused_rdata;

    assign eai_req_ready_o = (eai_req_instr_i[6:0] == CUSTOM0) && !q_full;
    assign push            = eai_req_valid_i && eai_req_ready_o;
    assign pop             = (state_q == ST_RESP) && eai_rsp_ready_i;
    assign push_entry      = '{hdr: '{instr: eai_req_instr_i, itag: eai_req_itag_i},
                               rs1: eai_req_rs1_i, rs2: eai_req_rs2_i};

    eai_instr_fifo #(
        .QDEPTH (QDEPTH),
        .WIDTH  ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // The head is always presented so the engine's wb decode is valid while it waits in the queue.
    assign eng_instr_o = head.hdr.instr;
    assign eng_rs1_o   = head.rs1;
    assign eng_rs2_o   = head.rs2;

    assign busy     = (state_q == ST_BUSY);
    assign ost_ok   = (ost_q < OW'(MAX_OST));
    assign done_acc = eng_done_i && ((state_q == ST_WAIT) || busy);

    assign eai_icb_cmd_valid_o = busy && wb_valid_i && ost_ok;
    assign wb_ready_o          = busy && eai_icb_cmd_ready_i && ost_ok;
    assign cmd_hs              = eai_icb_cmd_valid_o && eai_icb_cmd_ready_i;
    assign ost_dec             = eai_icb_rsp_valid_i && (ost_q != '0);
    assign eai_icb_cmd_addr_o  = addr_q;
    assign eai_icb_cmd_read_o  = 1'b0;
    assign eai_icb_cmd_wdata_o = wb_data_i;
    assign eai_icb_cmd_wmask_o = '1;
    assign eai_icb_rsp_ready_o = 1'b1;
    assign unused_rdata        = ^eai_icb_rsp_rdata_i;

    assign eai_mem_holdup_o = busy || (!q_empty && eng_wb_i);

    assign eai_rsp_valid_o = (state_q == ST_RESP);
    assign eai_rsp_wdat_o  = eai_rsp_valid_o ? result_q : '0;
    assign eai_rsp_itag_o  = eai_rsp_valid_o ? head.hdr.itag : '0;
    assign eai_rsp_err_o   = eai_rsp_valid_o && err_q;

    always_comb begin
        state_d     = state_q;
        eng_valid_o = 1'b0;
        case (state_q)
            ST_IDLE:  if (!q_empty) state_d = ST_ISSUE;
            ST_ISSUE: begin
                eng_valid_o = 1'b1;
                if (eng_ready_i) state_d = eng_wb_i ? ST_BUSY : ST_WAIT;
            end
            ST_WAIT:  if (eng_done_i) state_d = ST_RESP;
            ST_BUSY:  if (done_seen_q && last_seen_q && (ost_q == '0)) state_d = ST_RESP;
            ST_RESP:  if (eai_rsp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ost_q       <= '0;
            err_q       <= 1'b0;
            done_seen_q <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_hs && !ost_dec)      ost_q <= ost_q + OW'(1);
            else if (!cmd_hs && ost_dec) ost_q <= ost_q - OW'(1);
            if (pop)
                err_q <= 1'b0;
            else if ((done_acc && eng_err_i) || (eai_icb_rsp_valid_i && eai_icb_rsp_err_i))
                err_q <= 1'b1;
            if (state_q == ST_ISSUE) begin
                done_seen_q <= 1'b0;
                last_seen_q <= 1'b0;
            end else if (busy) begin
                if (eng_done_i)                                 done_seen_q <= 1'b1;
                if (wb_valid_i && wb_ready_o && wb_last_i)      last_seen_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_ISSUE) addr_q <= 32'(head.rs1);
        else if (cmd_hs)         addr_q <= addr_q + 32'(STRIDE);
        if (done_acc)            result_q <= eng_result_i;
    end

`ifdef EAI_ITF_PERF_CNT_EN
    logic [31:0] busy_cyc_q, instr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cyc_q  <= '0;
            instr_cnt_q <= '0;
        end else begin
            if ((state_q != ST_IDLE) && (busy_cyc_q != 32'hFFFF_FFFF)) busy_cyc_q  <= busy_cyc_q + 32'd1;
            if (pop && (instr_cnt_q != 32'hFFFF_FFFF))                 instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign perf_busy_cyc_o  = busy_cyc_q;
    assign perf_instr_cnt_o = instr_cnt_q;
`else
    assign perf_busy_cyc_o  = '0;
    assign perf_instr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_eai_itf_mq.sv
// Scoreboard bench for eai_itf_mq: directed requests with hand-computed responses, an engine
// model (wb decoded from instr[12], err from instr[13]) and an ICB slave with programmable latency.
module tb_eai_itf_mq;
    localparam int DW = 32;
    localparam int MAX_OST = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [31:0] req_instr = '0, req_rs1 = '0, req_rs2 = '0;
    logic [1:0] req_itag = '0;
    logic rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_wdat;
    logic [1:0] rsp_itag;
    logic icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0] icb_cmd_wmask;
    logic icb_rsp_valid, icb_rsp_err, icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic holdup, eng_valid, eng_ready, eng_done, eng_err, eng_wb;
    logic [31:0] eng_instr, eng_rs1, eng_rs2, eng_result;
    logic wb_valid, wb_ready, wb_last;
    logic [31:0] wb_data, perf_busy, perf_instr;

    typedef struct { logic [31:0] wdat; logic [1:0] itag; logic err; } exp_t;
    typedef struct { int due; logic err; } pend_t;
    exp_t sb[$];
    logic [31:0] exp_addr[$];
    pend_t pend[$];

    int pass_cnt = 0, total_cnt = 0, rsp_count = 0, cyc = 0;
    int icb_lat = 2, err_beat = -1, icb_beat = 0, tb_ost = 0, ost_peak = 0;

    assign eng_wb = eng_instr[12];

    eai_itf_mq #(.QDEPTH(4), .DW(DW), .STRIDE(8), .MAX_OST(MAX_OST)) dut (
        .clk(clk), .rst(rst),
        .eai_req_valid_i(req_valid), .eai_req_ready_o(req_ready), .eai_req_instr_i(req_instr),
        .eai_req_rs1_i(req_rs1), .eai_req_rs2_i(req_rs2), .eai_req_itag_i(req_itag),
        .eai_rsp_valid_o(rsp_valid), .eai_rsp_ready_i(rsp_ready), .eai_rsp_wdat_o(rsp_wdat),
        .eai_rsp_itag_o(rsp_itag), .eai_rsp_err_o(rsp_err),
        .eai_icb_cmd_valid_o(icb_cmd_valid), .eai_icb_cmd_ready_i(icb_cmd_ready),
        .eai_icb_cmd_addr_o(icb_cmd_addr), .eai_icb_cmd_read_o(icb_cmd_read),
        .eai_icb_cmd_wdata_o(icb_cmd_wdata), .eai_icb_cmd_wmask_o(icb_cmd_wmask),
        .eai_icb_rsp_valid_i(icb_rsp_valid), .eai_icb_rsp_err_i(icb_rsp_err),
        .eai_icb_rsp_ready_o(icb_rsp_ready), .eai_icb_rsp_rdata_i(icb_rsp_rdata),
        .eai_mem_holdup_o(holdup),
        .eng_valid_o(eng_valid), .eng_ready_i(eng_ready), .eng_instr_o(eng_instr),
        .eng_rs1_o(eng_rs1), .eng_rs2_o(eng_rs2), .eng_done_i(eng_done), .eng_err_i(eng_err),
        .eng_result_i(eng_result), .eng_wb_i(eng_wb),
        .wb_valid_i(wb_valid), .wb_ready_o(wb_ready), .wb_data_i(wb_data), .wb_last_i(wb_last),
        .perf_busy_cyc_o(perf_busy), .perf_instr_cnt_o(perf_instr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Engine: result = rs1 + rs2; wb instructions stream rs2[3:0] beats then pulse done.
    initial begin : engine
        logic [31:0] ci, c1, c2;
        int nb;
        eng_ready = 1'b1; eng_done = 1'b0; eng_err = 1'b0; eng_result = '0;
        wb_valid = 1'b0; wb_data = '0; wb_last = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!rst && eng_valid && eng_ready) begin
                ci = eng_instr; c1 = eng_rs1; c2 = eng_rs2;
                @(negedge clk);
                if (ci[12]) begin
                    nb = int'(c2[3:0]);
                    for (int b = 0; b < nb && !rst; ) begin
                        wb_valid = 1'b1; wb_data = c1 ^ b; wb_last = (b == nb - 1);
                        #1;
                        if (wb_ready) b++;
                        @(negedge clk);
                    end
                    wb_valid = 1'b0; wb_last = 1'b0;
                end else begin
                    repeat (4) @(negedge clk);
                end
                if (!rst) begin
                    eng_done = 1'b1; eng_result = c1 + c2; eng_err = ci[13];
                    @(negedge clk);
                    eng_done = 1'b0; eng_err = 1'b0;
                end
            end
        end
    end

    // ICB slave: checks each write command and answers after icb_lat cycles.
    initial begin : icb_model
        int ost_pre;
        icb_cmd_ready = 1'b1; icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0; icb_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0;
            if (rst) begin
                pend.delete();
                tb_ost = 0;
            end else begin
                ost_pre = tb_ost;
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    icb_rsp_valid = 1'b1; icb_rsp_err = pend[0].err;
                    void'(pend.pop_front());
                    tb_ost--;
                end
                #1;
                if (ost_pre >= MAX_OST) chk("ost_block", {wb_ready, icb_cmd_valid}, 2'b00);
                if (icb_cmd_valid && icb_cmd_ready) begin
                    chk("icb_ost_limit", ost_pre < MAX_OST, 1);
                    chk("icb_addr_queued", exp_addr.size() > 0, 1);
                    if (exp_addr.size() > 0) chk("icb_addr", icb_cmd_addr, exp_addr.pop_front());
                    chk("icb_read", icb_cmd_read, 0);
                    chk("icb_wmask", icb_cmd_wmask, 4'hF);
                    pend.push_back('{cyc + icb_lat, icb_beat == err_beat});
                    icb_beat++;
                    tb_ost++;
                    if (tb_ost > ost_peak) ost_peak = tb_ost;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every response handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && rsp_valid && rsp_ready) begin
                chk("rsp_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_itag", rsp_itag, e.itag);
                    chk("rsp_wdat", rsp_wdat, e.wdat);
                    chk("rsp_err", rsp_err, e.err);
                end
                rsp_count++;
            end
        end
    end

    task automatic send_req(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] tag, input logic [31:0] exp_wdat, input logic exp_err);
        int n = 0;
        req_valid = 1'b1; req_instr = ins; req_rs1 = a; req_rs2 = b; req_itag = tag;
        #1;
        while (!req_ready && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk("req_ready_timeout", req_ready, 1);
        if (req_ready) sb.push_back('{exp_wdat, tag, exp_err});
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || exp_addr.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain", sb.size() + exp_addr.size(), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rc, n;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", {rsp_wdat, rsp_itag, rsp_err}, 0);
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_icb_cmd_valid", icb_cmd_valid, 0);
        chk("rst_holdup_wbready", {holdup, wb_ready}, 0);
        chk("rst_perf", {perf_busy, perf_instr}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Non-CUSTOM0 opcode is never accepted
        req_valid = 1'b1; req_instr = 32'h0000_0033; req_itag = 2'd1;
        #1;
        chk("noncustom_ready", req_ready, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("noncustom_no_dispatch", {eng_valid, holdup}, 0);
        @(negedge clk);
        req_valid = 1'b0;

        // Four back-to-back requests fill the queue; the fifth waits for the first pop
        @(negedge clk);
        send_req(32'h0000_000B, 32'd0,  32'd0, 2'd0, 32'd0,  1'b0);
        send_req(32'h0000_000B, 32'd16, 32'd1, 2'd1, 32'd17, 1'b0);
        send_req(32'h0000_000B, 32'd32, 32'd2, 2'd2, 32'd34, 1'b0);
        send_req(32'h0000_000B, 32'd48, 32'd3, 2'd3, 32'd51, 1'b0);
        rc = rsp_count;
        req_instr = 32'h0000_000B;
        #1;
        chk("ready_when_full", req_ready, 0);
        chk("no_holdup_plain", holdup, 0);
        send_req(32'h0000_000B, 32'h100, 32'd1, 2'd0, 32'h101, 1'b0);
        chk("pops_before_5th", rsp_count - rc, 1);
        req_valid = 1'b0;
        wait_drain();
        chk("rsp_count_5", rsp_count, 5);

        // Write-back, 3 beats from 0x8000_0000
        icb_lat = 2; err_beat = -1; icb_beat = 0;
        exp_addr.push_back(32'h8000_0000);
        exp_addr.push_back(32'h8000_0008);
        exp_addr.push_back(32'h8000_0010);
        send_req(32'h0000_100B, 32'h8000_0000, 32'd3, 2'd1, 32'h8000_0003, 1'b0);
        req_valid = 1'b0;
        #1;
        chk("holdup_queued", holdup, 1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wb_rsp_seen", rsp_valid, 1);
        chk("holdup_at_rsp", holdup, 1);
        @(negedge clk); #1;
        chk("holdup_after_rsp", holdup, 0);
        wait_drain();

        // Outstanding limit with slow ICB responses
        icb_lat = 10; icb_beat = 0; ost_peak = 0;
        for (int k = 0; k < 4; k++) exp_addr.push_back(32'h1000_0000 + 32'(k * 8));
        send_req(32'h0000_100B, 32'h1000_0000, 32'd4, 2'd2, 32'h1000_0004, 1'b0);
        req_valid = 1'b0;
        wait_drain();
        chk("ost_peak", ost_peak, MAX_OST);

        // ICB error on beat 2 marks only that instruction; engine error on a later one
        icb_lat = 2; icb_beat = 0; err_beat = 1;
        exp_addr.push_back(32'h2000_0000);
        exp_addr.push_back(32'h2000_0008);
        exp_addr.push_back(32'h2000_0010);
        send_req(32'h0000_100B, 32'h2000_0000, 32'd3, 2'd3, 32'h2000_0003, 1'b1);
        send_req(32'h0000_000B, 32'd7, 32'd8, 2'd2, 32'd15, 1'b0);
        send_req(32'h0000_200B, 32'd1, 32'd1, 2'd1, 32'd2, 1'b1);
        req_valid = 1'b0;
        wait_drain();
        err_beat = -1;

        // Reset while BUSY: everything returns to reset values, no response follows
        icb_cmd_ready = 1'b0;
        send_req(32'h0000_100B, 32'h3000_0000, 32'd3, 2'd0, 32'h3000_0003, 1'b0);
        req_valid = 1'b0;
        n = 0;
        while (!wb_valid && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("busy_holdup", holdup, 1);
        rc = rsp_count;
        #2;
        rst = 1'b1;
        sb.delete();
        exp_addr.delete();
        #1;
        chk("midrst_valids", {rsp_valid, eng_valid, icb_cmd_valid, wb_ready}, 0);
        chk("midrst_holdup", holdup, 0);
        chk("midrst_rsp_data", {rsp_wdat, rsp_itag, rsp_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        icb_cmd_ready = 1'b1;
        repeat (25) @(negedge clk);
        #1;
        chk("no_rsp_after_rst", rsp_count - rc, 0);
        chk("idle_after_rst", {eng_valid, rsp_valid, holdup}, 0);
        chk("perf_tied_off", {perf_busy, perf_instr}, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
